// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and strobe sequencer for a 128Kx8 asynchronous SRAM.
// Every SRAM pin and user-side output is registered; one transaction per ACCESS_CYC+3 cycles.
module sram_arbiter_ctrl #(
    parameter int ACCESS_CYC = 6
) (
    input  logic        FPGA_CLK,
    input  logic        FPGA_RST,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [16:0] A_ADDR,
    input  logic [7:0]  A_WDATA,
    output logic        A_ACK,
    output logic [7:0]  A_RDATA,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [16:0] B_ADDR,
    input  logic [7:0]  B_WDATA,
    output logic        B_ACK,
    output logic [7:0]  B_RDATA,
    output logic        BUSY,
    output logic [16:0] SRAM_A,
    output logic [7:0]  SRAM_D_OUT,
    output logic        SRAM_D_OE,
    input  logic [7:0]  SRAM_D_IN,
    output logic        SRAM_CS1_B,
    output logic        SRAM_CS2,
    output logic        SRAM_OE_B,
    output logic        SRAM_WE_B
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last_b;   // 1 = port B was served last
    logic        cmd_b;    // winner tag of the transaction in flight
    logic        cmd_we;

    logic        grant_a;
    logic        sel_we;
    logic [16:0] sel_addr;
    logic [7:0]  sel_wdata;

    // A wins when alone, or on a tie when B was the last one served.
    assign grant_a   = A_REQ && (!B_REQ || last_b);
    assign sel_we    = grant_a ? A_WE    : B_WE;
    assign sel_addr  = grant_a ? A_ADDR  : B_ADDR;
    assign sel_wdata = grant_a ? A_WDATA : B_WDATA;

    // NOTE: all state and output registers use non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_b     <= 1'b1;
            cmd_b      <= 1'b0;
            cmd_we     <= 1'b0;
            A_ACK      <= 1'b0;
            B_ACK      <= 1'b0;
            A_RDATA    <= 8'h00;
            B_RDATA    <= 8'h00;
            BUSY       <= 1'b0;
            SRAM_A     <= 17'd0;
            SRAM_D_OUT <= 8'h00;
            SRAM_D_OE  <= 1'b0;
            SRAM_CS1_B <= 1'b1;
            SRAM_CS2   <= 1'b0;
            SRAM_OE_B  <= 1'b1;
            SRAM_WE_B  <= 1'b1;
        end else begin
            // NOTE: ACKs default low every cycle so they can only ever be one-cycle pulses.
            A_ACK <= 1'b0;
            B_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (A_REQ || B_REQ) begin
                        state      <= SETUP;
                        BUSY       <= 1'b1;
                        cmd_b      <= !grant_a;
                        last_b     <= !grant_a;
                        cmd_we     <= sel_we;
                        SRAM_A     <= sel_addr;
                        SRAM_D_OUT <= sel_wdata;
                        SRAM_D_OE  <= sel_we;
                        SRAM_CS1_B <= 1'b0;
                        SRAM_CS2   <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= 4'(ACCESS_CYC - 1);
                    if (cmd_we) SRAM_WE_B <= 1'b0;
                    else        SRAM_OE_B <= 1'b0;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= HOLD;
                        SRAM_OE_B <= 1'b1;
                        SRAM_WE_B <= 1'b1;
                        if (cmd_b) B_ACK <= 1'b1;
                        else       A_ACK <= 1'b1;
                        // Read data is sampled while OE_B is still low.
                        if (!cmd_we) begin
                            if (cmd_b) B_RDATA <= SRAM_D_IN;
                            else       A_RDATA <= SRAM_D_IN;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state      <= IDLE;
                    BUSY       <= 1'b0;
                    SRAM_CS1_B <= 1'b1;
                    SRAM_CS2   <= 1'b0;
                    SRAM_D_OE  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl with a behavioural 128Kx8 SRAM model.
// Outputs are sampled on the falling edge; cycle 0 is the cycle in which REQ is first sampled.
module tb_sram_arbiter_ctrl;

    logic        FPGA_CLK = 1'b0;
    logic        FPGA_RST = 1'b1;
    logic        A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [16:0] A_ADDR = '0, B_ADDR = '0;
    logic [7:0]  A_WDATA = '0, B_WDATA = '0;
    logic        A_ACK, B_ACK, BUSY, SRAM_D_OE;
    logic [7:0]  A_RDATA, B_RDATA, SRAM_D_OUT, SRAM_D_IN;
    logic [16:0] SRAM_A;
    logic        SRAM_CS1_B, SRAM_CS2, SRAM_OE_B, SRAM_WE_B;

    int total = 0;
    int bad   = 0;

    always #5 FPGA_CLK = ~FPGA_CLK;

    sram_arbiter_ctrl #(.ACCESS_CYC(6)) dut (
        .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_ACK(A_ACK), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_ACK(B_ACK), .B_RDATA(B_RDATA),
        .BUSY(BUSY), .SRAM_A(SRAM_A), .SRAM_D_OUT(SRAM_D_OUT), .SRAM_D_OE(SRAM_D_OE),
        .SRAM_D_IN(SRAM_D_IN), .SRAM_CS1_B(SRAM_CS1_B), .SRAM_CS2(SRAM_CS2),
        .SRAM_OE_B(SRAM_OE_B), .SRAM_WE_B(SRAM_WE_B)
    );

    // SRAM model: unwritten locations return a fixed pattern; floating bus reads as 8'hEE.
    logic [7:0] mem [0:131071];
    bit         written [0:131071];
    logic       contention = 1'b0;

    function automatic logic [7:0] pattern(input logic [16:0] a);
        if (a == 17'h1ABCD) return 8'h5A;
        return a[7:0] ^ 8'h3C;
    endfunction

    wire sram_sel = !SRAM_CS1_B && SRAM_CS2;
    assign SRAM_D_IN = (sram_sel && !SRAM_OE_B && !SRAM_D_OE)
                       ? (written[SRAM_A] ? mem[SRAM_A] : pattern(SRAM_A)) : 8'hEE;

    always @(posedge FPGA_CLK) begin
        if (sram_sel && !SRAM_WE_B) begin
            mem[SRAM_A]     <= SRAM_D_OUT;
            written[SRAM_A] <= 1'b1;
        end
    end

    always @(negedge FPGA_CLK) begin
        if (!SRAM_OE_B && SRAM_D_OE) contention <= 1'b1;
    end

    // Runs one transaction on one port and records per-cycle activity masks (bit = cycle).
    task automatic run_txn(input bit on_b, input bit we, input logic [16:0] addr,
                           input logic [7:0] wd,
                           output logic [15:0] oe_m, output logic [15:0] we_m,
                           output logic [15:0] doe_m, output logic [15:0] cs_m,
                           output logic [15:0] acka_m, output logic [15:0] ackb_m,
                           output logic [7:0] dout2, output logic [16:0] a2);
        oe_m = '0; we_m = '0; doe_m = '0; cs_m = '0; acka_m = '0; ackb_m = '0;
        dout2 = '0; a2 = '0;
        @(negedge FPGA_CLK);
        if (on_b) begin B_REQ = 1'b1; B_WE = we; B_ADDR = addr; B_WDATA = wd; end
        else      begin A_REQ = 1'b1; A_WE = we; A_ADDR = addr; A_WDATA = wd; end
        for (int c = 1; c <= 12; c++) begin
            @(negedge FPGA_CLK);
            oe_m[c]   = !SRAM_OE_B;
            we_m[c]   = !SRAM_WE_B;
            doe_m[c]  = SRAM_D_OE;
            cs_m[c]   = sram_sel;
            acka_m[c] = A_ACK;
            ackb_m[c] = B_ACK;
            if (c == 2) begin dout2 = SRAM_D_OUT; a2 = SRAM_A; end
            // Scrambled inputs after grant must not disturb the latched command.
            if (c == 1) begin
                if (on_b) begin B_ADDR = ~addr; B_WDATA = ~wd; end
                else      begin A_ADDR = ~addr; A_WDATA = ~wd; end
            end
            if (A_ACK) A_REQ = 1'b0;
            if (B_ACK) B_REQ = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [59:0] got, exp;
        FPGA_RST = 1'b1;
        repeat (3) @(negedge FPGA_CLK);
        got = {SRAM_A, SRAM_D_OUT, SRAM_D_OE, SRAM_CS1_B, SRAM_CS2, SRAM_OE_B, SRAM_WE_B,
               A_ACK, B_ACK, A_RDATA, B_RDATA, BUSY, 17'd0};
        exp = {17'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 17'd0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", got, exp);
        end
        FPGA_RST = 1'b0;
        repeat (2) @(negedge FPGA_CLK);
        total++;
        if (BUSY !== 1'b0 || SRAM_CS1_B !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle busy=%b cs1_b=%b exp busy=0 cs1_b=1", BUSY, SRAM_CS1_B);
        end
    endtask

    task automatic test_single_read_a();
        logic [15:0] oe_m, we_m, doe_m, cs_m, acka_m, ackb_m;
        logic [7:0]  dout2;
        logic [16:0] a2;
        run_txn(1'b0, 1'b0, 17'h1ABCD, 8'h00, oe_m, we_m, doe_m, cs_m, acka_m, ackb_m, dout2, a2);
        total++;
        if (oe_m !== 16'h00FC) begin bad++; $display("FAIL read_a_oe got=%h exp=00fc", oe_m); end
        total++;
        if (acka_m !== 16'h0100) begin bad++; $display("FAIL read_a_ack got=%h exp=0100", acka_m); end
        total++;
        if (ackb_m !== 16'h0000) begin bad++; $display("FAIL read_a_backk got=%h exp=0000", ackb_m); end
        total++;
        if (cs_m !== 16'h01FE || we_m !== 16'h0000 || doe_m !== 16'h0000) begin
            bad++;
            $display("FAIL read_a_strobes cs=%h we=%h doe=%h exp cs=01fe we=0 doe=0", cs_m, we_m, doe_m);
        end
        total++;
        if (a2 !== 17'h1ABCD) begin bad++; $display("FAIL read_a_addr got=%h exp=1abcd", a2); end
        total++;
        if (A_RDATA !== 8'h5A) begin bad++; $display("FAIL read_a_rdata got=%h exp=5a", A_RDATA); end
    endtask

    task automatic test_write_readback_b();
        logic [15:0] oe_m, we_m, doe_m, cs_m, acka_m, ackb_m;
        logic [7:0]  dout2;
        logic [16:0] a2;
        run_txn(1'b1, 1'b1, 17'h1FFFF, 8'hC3, oe_m, we_m, doe_m, cs_m, acka_m, ackb_m, dout2, a2);
        total++;
        if (we_m !== 16'h00FC || oe_m !== 16'h0000) begin
            bad++;
            $display("FAIL write_b_we we=%h oe=%h exp we=00fc oe=0", we_m, oe_m);
        end
        total++;
        if (doe_m !== 16'h01FE) begin bad++; $display("FAIL write_b_doe got=%h exp=01fe", doe_m); end
        total++;
        if (ackb_m !== 16'h0100 || acka_m !== 16'h0000) begin
            bad++;
            $display("FAIL write_b_ack b=%h a=%h exp b=0100 a=0", ackb_m, acka_m);
        end
        total++;
        if (dout2 !== 8'hC3 || a2 !== 17'h1FFFF) begin
            bad++;
            $display("FAIL write_b_bus dout=%h addr=%h exp dout=c3 addr=1ffff", dout2, a2);
        end
        run_txn(1'b1, 1'b0, 17'h1FFFF, 8'h00, oe_m, we_m, doe_m, cs_m, acka_m, ackb_m, dout2, a2);
        total++;
        if (oe_m !== 16'h00FC || ackb_m !== 16'h0100) begin
            bad++;
            $display("FAIL readback_b_timing oe=%h ack=%h exp oe=00fc ack=0100", oe_m, ackb_m);
        end
        total++;
        if (B_RDATA !== 8'hC3) begin bad++; $display("FAIL readback_b_rdata got=%h exp=c3", B_RDATA); end
        total++;
        if (A_RDATA !== 8'h5A) begin bad++; $display("FAIL loser_rdata_a got=%h exp=5a", A_RDATA); end
    endtask

    task automatic test_tie_arbitration();
        int          n = 0;
        int          ack_cyc [4];
        logic [1:0]  ack_who [4];   // 1 = A, 2 = B
        logic [7:0]  ack_dat [4];
        int          exp_cyc [4] = '{8, 17, 26, 35};
        FPGA_RST = 1'b1;
        repeat (2) @(negedge FPGA_CLK);
        FPGA_RST = 1'b0;
        @(negedge FPGA_CLK);
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 17'h00044;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 17'h00055;
        for (int c = 1; c <= 45; c++) begin
            @(negedge FPGA_CLK);
            if ((A_ACK || B_ACK) && n < 4) begin
                ack_cyc[n] = c;
                ack_who[n] = {B_ACK, A_ACK};
                ack_dat[n] = A_ACK ? A_RDATA : B_RDATA;
                n++;
                if (n == 4) begin A_REQ = 1'b0; B_REQ = 1'b0; end
            end
        end
        total++;
        if (n !== 4) begin bad++; $display("FAIL tie_ack_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (ack_who[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || ack_cyc[i] !== exp_cyc[i]) begin
                bad++;
                $display("FAIL tie_order[%0d] who=%b cyc=%0d exp who=%b cyc=%0d", i, ack_who[i],
                         ack_cyc[i], (i % 2 == 0) ? 2'b01 : 2'b10, exp_cyc[i]);
            end
            total++;
            if (ack_dat[i] !== ((i % 2 == 0) ? 8'h78 : 8'h69)) begin
                bad++;
                $display("FAIL tie_rdata[%0d] got=%h exp=%h", i, ack_dat[i],
                         (i % 2 == 0) ? 8'h78 : 8'h69);
            end
        end
    endtask

    task automatic test_single_requester_b();
        int          n = 0;
        int          a_acks = 0;
        logic [16:0] addrs [3] = '{17'h00011, 17'h00022, 17'h00033};
        logic [7:0]  exp_d [3] = '{8'h2D, 8'h1E, 8'h0F};
        int          exp_cyc [3] = '{8, 17, 26};
        @(negedge FPGA_CLK);
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = addrs[0];
        for (int c = 1; c <= 35; c++) begin
            @(negedge FPGA_CLK);
            if (A_ACK) a_acks++;
            if (B_ACK && n < 3) begin
                total++;
                if (c !== exp_cyc[n] || B_RDATA !== exp_d[n]) begin
                    bad++;
                    $display("FAIL b_only[%0d] cyc=%0d data=%h exp cyc=%0d data=%h", n, c, B_RDATA,
                             exp_cyc[n], exp_d[n]);
                end
                n++;
                if (n == 3) B_REQ = 1'b0;
                else        B_ADDR = addrs[n];
            end
        end
        total++;
        if (n !== 3 || a_acks !== 0) begin
            bad++;
            $display("FAIL b_only_count b_acks=%0d a_acks=%0d exp 3 and 0", n, a_acks);
        end
    endtask

    task automatic test_turnaround();
        int   oe_rise = -1;
        int   doe_rise = -1;
        int   b_ack_cyc = -1;
        logic prev_oe_b = 1'b1;
        logic prev_doe = 1'b0;
        @(negedge FPGA_CLK);
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 17'h00066;
        for (int c = 1; c <= 22; c++) begin
            @(negedge FPGA_CLK);
            if (SRAM_OE_B && !prev_oe_b && oe_rise < 0) oe_rise = c;
            if (SRAM_D_OE && !prev_doe && doe_rise < 0) doe_rise = c;
            if (B_ACK && b_ack_cyc < 0) b_ack_cyc = c;
            prev_oe_b = SRAM_OE_B;
            prev_doe  = SRAM_D_OE;
            if (A_ACK) begin
                A_REQ = 1'b0;
                B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 17'h00077; B_WDATA = 8'h99;
            end
            if (B_ACK) B_REQ = 1'b0;
        end
        total++;
        if (oe_rise !== 8 || doe_rise !== 10) begin
            bad++;
            $display("FAIL turnaround oe_rise=%0d doe_rise=%0d exp 8 and 10", oe_rise, doe_rise);
        end
        total++;
        if (b_ack_cyc !== 17 || A_RDATA !== 8'h5A) begin
            bad++;
            $display("FAIL turnaround_txn b_ack=%0d a_rdata=%h exp 17 and 5a", b_ack_cyc, A_RDATA);
        end
        total++;
        if (mem[17'h00077] !== 8'h99) begin
            bad++;
            $display("FAIL turnaround_write got=%h exp=99", mem[17'h00077]);
        end
        total++;
        if (contention !== 1'b0) begin bad++; $display("FAIL bus_contention got=1 exp=0"); end
    endtask

    task automatic test_reset_mid_op();
        int acks = 0;
        int busy_cycles = 0;
        @(negedge FPGA_CLK);
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 17'h00010; A_WDATA = 8'h77;
        for (int c = 1; c <= 4; c++) @(negedge FPGA_CLK);
        total++;
        if (SRAM_WE_B !== 1'b0) begin bad++; $display("FAIL midop_pre we_b=%b exp=0", SRAM_WE_B); end
        FPGA_RST = 1'b1;
        A_REQ    = 1'b0;
        @(negedge FPGA_CLK);
        total++;
        if ({SRAM_WE_B, SRAM_CS1_B, SRAM_CS2, SRAM_OE_B, SRAM_D_OE, A_ACK, BUSY} !== 7'b1101000) begin
            bad++;
            $display("FAIL midop_reset we_b=%b cs1_b=%b cs2=%b oe_b=%b doe=%b ack=%b busy=%b exp 1101000",
                     SRAM_WE_B, SRAM_CS1_B, SRAM_CS2, SRAM_OE_B, SRAM_D_OE, A_ACK, BUSY);
        end
        total++;
        if (A_RDATA !== 8'h00 || B_RDATA !== 8'h00) begin
            bad++;
            $display("FAIL midop_rdata a=%h b=%h exp 00 and 00", A_RDATA, B_RDATA);
        end
        FPGA_RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge FPGA_CLK);
            if (A_ACK || B_ACK) acks++;
            if (BUSY) busy_cycles++;
        end
        total++;
        if (acks !== 0 || busy_cycles !== 0) begin
            bad++;
            $display("FAIL midop_after acks=%0d busy=%0d exp 0 and 0", acks, busy_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_single_read_a();
        test_write_readback_b();
        test_tie_arbitration();
        test_single_requester_b();
        test_turnaround();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_ctrl.md
# sram_arbiter_ctrl

Two-port controller for the on-board 128K×8 asynchronous SRAM (IS62WV1288BL-55, 55 ns access). It arbitrates between requester A and requester B, then sequences the SRAM strobes to meet device timing at the 100 MHz board clock. It sits between user logic and the top-level SRAM pins; the top level drives the bidirectional SRAM_D bus through a tri-state buffer using SRAM_D_OUT, SRAM_D_OE and SRAM_D_IN.

## Interface
- ACCESS_CYC, 6, cycles the OE_B or WE_B strobe stays low; legal range 1..15; 6 gives 60 ns ≥ 55 ns at 100 MHz.

Ports:
- FPGA_CLK  in  1  100 MHz clock; all logic on the rising edge.
- FPGA_RST  in  1  synchronous, active-high reset.
- A_REQ / B_REQ  in  1  request; held high until the matching ACK.
- A_WE / B_WE  in  1  1 = write, 0 = read.
- A_ADDR / B_ADDR  in  17  byte address.
- A_WDATA / B_WDATA  in  8  write data.
- A_ACK / B_ACK  out  1  one-cycle completion pulse.
- A_RDATA / B_RDATA  out  8  read data; valid from the ACK cycle and held until the next read completes on that port.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- SRAM_A  out  17  SRAM address.
- SRAM_D_OUT  out  8  write data to the pad.
- SRAM_D_OE  out  1  1 = FPGA drives SRAM_D.
- SRAM_D_IN  in  8  data from the pad.
- SRAM_CS1_B, SRAM_CS2, SRAM_OE_B, SRAM_WE_B  out  1 each  SRAM strobes.

## Operation
- **FSM states:** IDLE → SETUP → ACCESS → HOLD → IDLE.
- **IDLE:**
  - Strobes inactive: CS1_B=1, CS2=0, OE_B=1, WE_B=1, D_OE=0.
  - If any REQ is high, arbitrate. Latch the winner's WE, ADDR and WDATA, plus a winner tag. Go to SETUP.
- **Arbitration:** round-robin with a 1-bit last-served pointer.
  - A single requester always wins.
  - If both request, the port not last served wins.
  - Pointer resets to "B last served", so A wins the first tie.
  - The pointer updates at grant.
- **SETUP (1 cycle):**
  - SRAM_A = latched address; CS1_B=0, CS2=1.
  - Write: D_OE=1 and SRAM_D_OUT = latched data.
  - OE_B and WE_B stay high.
- **ACCESS (ACCESS_CYC cycles, 4-bit down-counter):**
  - Read: OE_B=0.
  - Write: WE_B=0, data still driven.
  - Address and CS are held throughout.
  - Read only: SRAM_D_IN is registered into the winner's RDATA register on the clock edge that ends the last ACCESS cycle.
- **HOLD (1 cycle):**
  - OE_B=1 and WE_B=1.
  - CS, address and (for writes) D_OE and data are held, giving write-data hold and address hold.
  - The winner's ACK = 1 in this cycle.
  - Next state is IDLE.
- **Command latching:** the command is latched at grant. Changes to REQ, ADDR or WDATA after grant do not affect the transaction in flight. REQ must fall in the cycle after ACK, otherwise a new transaction is granted.
- **Bus turnaround:** IDLE always lasts at least 1 cycle between transactions. This gives ≥20 ns from OE_B rising to the next D_OE assertion (covers tHZOE).
- The non-winning port's RDATA never changes.

## Timing
- Reset values: SRAM_A=0, SRAM_D_OUT=0, SRAM_D_OE=0, CS1_B=1, CS2=0, OE_B=1, WE_B=1, ACKs=0, RDATAs=0, BUSY=0, FSM=IDLE, pointer="B last".
- All outputs are registered.
- Cycle numbering: cycle 0 is the IDLE cycle in which REQ is sampled.
  - SETUP = cycle 1.
  - ACCESS = cycles 2 .. ACCESS_CYC+1.
  - HOLD / ACK = cycle ACCESS_CYC+2 (cycle 8 by default).
- Back-to-back throughput: one transaction per ACCESS_CYC+3 cycles (9 by default).
- Reset asserted mid-transaction:
  - The next edge forces the reset values: strobes inactive, D_OE=0.
  - No ACK is issued; the aborted write is undefined in the SRAM.
  - RDATA is cleared.
- REQ on both ports in the same cycle as reset deassertion: not granted until the first IDLE cycle after reset is released.

## Test plan
- **Single read A:** ACCESS_CYC=6, A_REQ, A_WE=0, A_ADDR=17'h1ABCD, SRAM model returns 8'h5A → OE_B low for exactly cycles 2–7, A_ACK only in cycle 8, A_RDATA=8'h5A, B_ACK never asserts.
- **Write then readback B:** write 8'hC3 to 17'h1FFFF, then read it back → WE_B low 6 cycles with D_OE=1 spanning cycles 1–8, then B_RDATA=8'hC3.
- **Tie arbitration:** A and B request together and hold for 4 transactions → grant order A, B, A, B; ACKs 9 cycles apart.
- **Single requester starvation-free:** only B requests continuously for 3 transactions → all granted to B with no idle penalty beyond the 1-cycle IDLE.
- **Reset mid-op:** assert FPGA_RST during cycle 4 of a write → next edge has WE_B=1, CS1_B=1, D_OE=0, no ACK, FSM=IDLE.
- **Turnaround check:** a read on A immediately followed by a write on B → ≥2 cycles between OE_B rising and D_OE rising; the model flags no bus contention.
